// File: rtl/audio_codec_port_pkg.sv
// Shared types and defaults for the I2S codec port: sample width and FSM state encodings.
package audio_codec_port_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ADC_IDLE  = 2'd0,
        ADC_SKIP  = 2'd1,
        ADC_SHIFT = 2'd2,
        ADC_HOLD  = 2'd3
    } adc_state_t;

    typedef enum logic [1:0] {
        DAC_IDLE = 2'd0,
        DAC_SKIP = 2'd1,
        DAC_SEND = 2'd2,
        DAC_PAD  = 2'd3
    } dac_state_t;

endpackage

// File: rtl/audio_codec_port_edge_sync.sv
// Multi-flop synchronizer for one codec input, with one-clock rise/fall strobes
// taken from the synchronized level.
module codec_edge_sync
    import audio_codec_port_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~last_q;
    assign fall  = ~level & last_q;

endmodule

// File: rtl/audio_codec_port.sv
// I2S bridge: left ADC slot -> parallel input_sample + sample_clock, and
// output_sample -> both DAC slots. Codec is clock master; all codec pins are oversampled.
//
// ADC FSM   | meaning
// IDLE      | waiting for adclrck fall (start of left slot)
// SKIP      | discarding the first bclk rise (I2S one-bit delay)
// SHIFT     | capturing SAMPLE_WIDTH bits MSB first
// HOLD      | word complete, ignoring extra bits until adclrck rise commits it
//
// DAC FSM   | meaning
// IDLE      | nothing loaded since reset
// SKIP      | word loaded, discarding the delay-bit bclk fall
// SEND      | driving tx MSB first on each bclk fall
// PAD       | word sent, driving 0 until the next daclrck edge
module audio_codec_port
    import audio_codec_port_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    aud_bclk,
    input  logic                    aud_adclrck,
    input  logic                    aud_adcdat,
    input  logic                    aud_daclrck,
    output logic                    aud_dacdat,
    input  logic [SAMPLE_WIDTH-1:0] output_sample,
    output logic [SAMPLE_WIDTH-1:0] input_sample,
    output logic                    sample_clock,
    output logic                    sample_valid,
    output logic                    frame_error
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);

    logic       bclk_rise, bclk_fall;
    logic       adclrck_rise, adclrck_fall;
    logic       daclrck_rise, daclrck_fall;
    logic       adcdat_s;
    logic [4:0] sync_unused;

    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clock(clock), .reset(reset), .din(aud_bclk),
        .level(sync_unused[0]), .rise(bclk_rise), .fall(bclk_fall)
    );
    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adclrck (
        .clock(clock), .reset(reset), .din(aud_adclrck),
        .level(sync_unused[1]), .rise(adclrck_rise), .fall(adclrck_fall)
    );
    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_daclrck (
        .clock(clock), .reset(reset), .din(aud_daclrck),
        .level(sync_unused[2]), .rise(daclrck_rise), .fall(daclrck_fall)
    );
    codec_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_adcdat (
        .clock(clock), .reset(reset), .din(aud_adcdat),
        .level(adcdat_s), .rise(sync_unused[3]), .fall(sync_unused[4])
    );

    // ADC path
    adc_state_t              adc_state, adc_next;
    logic [SAMPLE_WIDTH-1:0] adc_shift, adc_shift_next;
    logic [CW-1:0]           adc_count, adc_count_next;
    logic                    adc_commit, adc_error, sclk_pending;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adc_state    <= ADC_IDLE;
            adc_shift    <= '0;
            adc_count    <= '0;
            input_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            sclk_pending <= 1'b0;
            sample_clock <= 1'b0;
        end else begin
            adc_state    <= adc_next;
            adc_shift    <= adc_shift_next;
            adc_count    <= adc_count_next;
            sample_valid <= adc_commit;
            frame_error  <= adc_error;
            sclk_pending <= adc_commit;
            if (adc_commit) begin
                input_sample <= adc_shift;
            end
            // The rise trails input_sample by one clock so DSP logic sees settled data.
            if (adclrck_fall) begin
                sample_clock <= 1'b0;
            end else if (sclk_pending) begin
                sample_clock <= 1'b1;
            end
        end
    end

    always_comb begin
        adc_next       = adc_state;
        adc_shift_next = adc_shift;
        adc_count_next = adc_count;
        adc_commit     = 1'b0;
        adc_error      = 1'b0;
        unique case (adc_state)
            ADC_IDLE: begin
                if (adclrck_fall) adc_next = ADC_SKIP;
            end
            ADC_SKIP: begin
                if (adclrck_rise) begin
                    adc_error = 1'b1;
                    adc_next  = ADC_IDLE;
                end else if (bclk_rise) begin
                    adc_count_next = '0;
                    adc_next       = ADC_SHIFT;
                end
            end
            ADC_SHIFT: begin
                if (adclrck_rise) begin
                    adc_error = 1'b1;
                    adc_next  = ADC_IDLE;
                end else if (bclk_rise) begin
                    adc_shift_next = {adc_shift[SAMPLE_WIDTH-2:0], adcdat_s};
                    adc_count_next = adc_count + 1'b1;
                    if (adc_count_next == CW'(SAMPLE_WIDTH)) adc_next = ADC_HOLD;
                end
            end
            ADC_HOLD: begin
                if (adclrck_rise) begin
                    adc_commit = 1'b1;
                    adc_next   = ADC_IDLE;
                end
            end
        endcase
        // A left-slot start anywhere resynchronizes the capture.
        if (adclrck_fall) begin
            adc_next       = ADC_SKIP;
            adc_count_next = '0;
        end
    end

    // DAC path
    dac_state_t              dac_state, dac_next;
    logic [SAMPLE_WIDTH-1:0] tx_shift, tx_shift_next;
    logic [CW-1:0]           dac_count, dac_count_next;
    logic                    dacdat_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dac_state  <= DAC_IDLE;
            tx_shift   <= '0;
            dac_count  <= '0;
            aud_dacdat <= 1'b0;
        end else begin
            dac_state  <= dac_next;
            tx_shift   <= tx_shift_next;
            dac_count  <= dac_count_next;
            aud_dacdat <= dacdat_next;
        end
    end

    always_comb begin
        dac_next       = dac_state;
        tx_shift_next  = tx_shift;
        dac_count_next = dac_count;
        dacdat_next    = aud_dacdat;
        if (daclrck_rise || daclrck_fall) begin
            // The bclk fall that carries the frame edge is the delay bit itself.
            tx_shift_next  = output_sample;
            dac_count_next = '0;
            dacdat_next    = 1'b0;
            dac_next       = bclk_fall ? DAC_SEND : DAC_SKIP;
        end else begin
            unique case (dac_state)
                DAC_IDLE: ;
                DAC_SKIP: begin
                    if (bclk_fall) dac_next = DAC_SEND;
                end
                DAC_SEND: begin
                    if (bclk_fall) begin
                        dacdat_next    = tx_shift[SAMPLE_WIDTH-1];
                        tx_shift_next  = {tx_shift[SAMPLE_WIDTH-2:0], 1'b0};
                        dac_count_next = dac_count + 1'b1;
                        if (dac_count == CW'(SAMPLE_WIDTH - 1)) dac_next = DAC_PAD;
                    end
                end
                DAC_PAD: begin
                    if (bclk_fall) dacdat_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_codec_port.sv
// Directed bench for audio_codec_port: codec pins driven as an I2S master with
// bclk = clock/8 and 64 bclks per frame.
module tb_audio_codec_port;

    logic        clock;
    logic        reset;
    logic        aud_bclk;
    logic        aud_adclrck;
    logic        aud_adcdat;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic [15:0] output_sample;
    logic [15:0] input_sample;
    logic        sample_clock;
    logic        sample_valid;
    logic        frame_error;

    int n_cmp = 0;
    int n_bad = 0;

    audio_codec_port #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
        .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
        .output_sample(output_sample), .input_sample(input_sample),
        .sample_clock(sample_clock), .sample_valid(sample_valid), .frame_error(frame_error)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Pulse counters and sample_clock timing observed on the falling clock edge.
    int   cyc = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   rise_cnt = 0;
    int   rise_bad = 0;
    int   period_bad = 0;
    int   high_bad = 0;
    int   last_rise = 0;
    logic have_rise = 1'b0;
    logic prev_sc = 1'b0;
    logic prev_valid = 1'b0;
    logic measure_en = 1'b0;

    always @(negedge clock) begin
        if (sample_valid) valid_cnt++;
        if (frame_error) err_cnt++;
        if (sample_clock && !prev_sc) begin
            rise_cnt++;
            if (!prev_valid) rise_bad++;
            if (measure_en && have_rise && (cyc - last_rise) != 512) period_bad++;
            last_rise = cyc;
            have_rise = 1'b1;
        end
        if (!sample_clock && prev_sc && measure_en &&
            ((cyc - last_rise) < 250 || (cyc - last_rise) > 260)) high_bad++;
        prev_sc    = sample_clock;
        prev_valid = sample_valid;
        cyc++;
    end

    task automatic bit_period(input logic lr, input logic d, output logic dac_at_rise);
        @(negedge clock);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_daclrck = lr;
        aud_adcdat  = d;
        repeat (4) @(negedge clock);
        dac_at_rise = aud_dacdat;
        aud_bclk    = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic left_slot(input logic [31:0] data, input int n);
        logic x;
        bit_period(1'b0, 1'b0, x);
        for (int i = n - 1; i >= 0; i--) bit_period(1'b0, data[i], x);
    endtask

    task automatic right_slot(input int n);
        logic x;
        for (int i = 0; i < n; i++) bit_period(1'b1, 1'b0, x);
    endtask

    task automatic std_frame(input logic [15:0] w);
        left_slot({1'b0, w, 15'h0}, 31);
        right_slot(32);
    endtask

    task automatic test_reset();
        int v0, r0;
        logic x;
        reset = 1'b0; aud_bclk = 1'b0; aud_adclrck = 1'b1; aud_daclrck = 1'b1;
        aud_adcdat = 1'b0; output_sample = 16'h0;
        repeat (5) @(negedge clock);
        n_cmp++; if (input_sample !== 16'h0) begin n_bad++; $display("FAIL reset_input_sample: got %h want 0000", input_sample); end
        n_cmp++; if (sample_clock !== 1'b0) begin n_bad++; $display("FAIL reset_sample_clock: got %b want 0", sample_clock); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sample_valid: got %b want 0", sample_valid); end
        n_cmp++; if (frame_error !== 1'b0) begin n_bad++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
        n_cmp++; if (aud_dacdat !== 1'b0) begin n_bad++; $display("FAIL reset_dacdat: got %b want 0", aud_dacdat); end
        reset = 1'b1;
        right_slot(8);
        // Reset pulse in the middle of a left slot carrying 16 ones.
        bit_period(1'b0, 1'b0, x);
        for (int i = 0; i < 8; i++) bit_period(1'b0, 1'b1, x);
        @(negedge clock); reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (sample_clock !== 1'b0) begin n_bad++; $display("FAIL midreset_sample_clock: got %b want 0", sample_clock); end
        for (int i = 0; i < 4; i++) bit_period(1'b0, 1'b1, x);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bit_period(1'b0, 1'b1, x);
        v0 = valid_cnt; r0 = rise_cnt;
        right_slot(32);
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL midreset_no_valid: got %0d pulses want 0", valid_cnt - v0); end
        n_cmp++; if (input_sample !== 16'h0) begin n_bad++; $display("FAIL midreset_input_sample: got %h want 0000", input_sample); end
        v0 = valid_cnt;
        std_frame(16'hA5C3);
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL first_frame_valid_count: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (input_sample !== 16'hA5C3) begin n_bad++; $display("FAIL first_frame_sample: got %h want a5c3", input_sample); end
        n_cmp++; if (rise_cnt - r0 !== 1) begin n_bad++; $display("FAIL first_frame_sclk_rises: got %0d want 1", rise_cnt - r0); end
        n_cmp++; if (rise_bad !== 0) begin n_bad++; $display("FAIL sclk_after_valid: got %0d misplaced rises want 0", rise_bad); end
    endtask

    task automatic test_long_slot();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        left_slot({8'h00, 16'h8001, 8'hFF}, 24);
        right_slot(32);
        n_cmp++; if (valid_cnt - v0 !== 1) begin n_bad++; $display("FAIL long_slot_valid: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (input_sample !== 16'h8001) begin n_bad++; $display("FAIL long_slot_sample: got %h want 8001", input_sample); end
        n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL long_slot_error: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_short_slot();
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        left_slot({22'h0, 10'h2AB}, 10);
        right_slot(32);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL short_slot_error: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL short_slot_valid: got %0d want 0", valid_cnt - v0); end
        n_cmp++; if (input_sample !== 16'h8001) begin n_bad++; $display("FAIL short_slot_hold: got %h want 8001", input_sample); end
    endtask

    task automatic test_dac();
        logic [63:0] cap;
        logic [15:0] w;
        logic        expb;
        int          k;
        w = 16'h1234;
        output_sample = w;
        for (int i = 0; i < 64; i++) bit_period(i >= 32, 1'b0, cap[i]);
        for (int s = 0; s < 2; s++) begin
            for (int j = 1; j < 32; j++) begin
                k = s * 32 + j;
                expb = (j <= 16) ? w[16 - j] : 1'b0;
                n_cmp++;
                if (cap[k] !== expb) begin
                    n_bad++;
                    $display("FAIL dac_slot%0d_bit%0d: got %b want %b", s, j, cap[k], expb);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        int v0, e0;
        logic [15:0] w;
        logic x;
        w = 16'h5A3C;
        bit_period(1'b0, 1'b0, x);
        for (int i = 15; i >= 0; i--) bit_period(1'b0, w[i], x);
        @(negedge clock); aud_bclk = 1'b0; aud_adcdat = 1'b0;
        repeat (4) @(negedge clock);
        aud_bclk = 1'b1; aud_adclrck = 1'b1; aud_daclrck = 1'b1;
        @(negedge clock);
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL latency_cycle1: got %b want 0", sample_valid); end
        @(negedge clock);
        n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL latency_cycle2: got %b want 0", sample_valid); end
        @(negedge clock);
        n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL latency_cycle3_valid: got %b want 1", sample_valid); end
        n_cmp++; if (input_sample !== 16'h5A3C) begin n_bad++; $display("FAIL same_cycle_commit: got %h want 5a3c", input_sample); end
        @(negedge clock);
        right_slot(31);
        // Frame edge coinciding with the 16th bclk rise must win: truncated slot.
        v0 = valid_cnt; e0 = err_cnt;
        bit_period(1'b0, 1'b0, x);
        for (int i = 0; i < 15; i++) bit_period(1'b0, 1'b1, x);
        @(negedge clock); aud_bclk = 1'b0; aud_adcdat = 1'b1;
        repeat (4) @(negedge clock);
        aud_bclk = 1'b1; aud_adclrck = 1'b1; aud_daclrck = 1'b1;
        repeat (8) @(negedge clock);
        n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL same_cycle_trunc_error: got %0d want 1", err_cnt - e0); end
        n_cmp++; if (valid_cnt - v0 !== 0) begin n_bad++; $display("FAIL same_cycle_trunc_valid: got %0d want 0", valid_cnt - v0); end
        n_cmp++; if (input_sample !== 16'h5A3C) begin n_bad++; $display("FAIL same_cycle_trunc_hold: got %h want 5a3c", input_sample); end
        right_slot(30);
    endtask

    task automatic test_stream();
        int v0, r0;
        logic [15:0] w;
        v0 = valid_cnt; r0 = rise_cnt;
        for (int i = 0; i < 100; i++) begin
            w = 16'((i * 941 + 4369) & 16'hFFFF);
            std_frame(w);
            if (i == 0) measure_en = 1'b1;
            n_cmp++;
            if (input_sample !== w) begin
                n_bad++;
                $display("FAIL stream_sample_%0d: got %h want %h", i, input_sample, w);
            end
        end
        measure_en = 1'b0;
        n_cmp++; if (valid_cnt - v0 !== 100) begin n_bad++; $display("FAIL stream_valid_count: got %0d want 100", valid_cnt - v0); end
        n_cmp++; if (rise_cnt - r0 !== 100) begin n_bad++; $display("FAIL stream_sclk_rises: got %0d want 100", rise_cnt - r0); end
        n_cmp++; if (period_bad !== 0) begin n_bad++; $display("FAIL stream_sclk_period: got %0d periods off 512 want 0", period_bad); end
        n_cmp++; if (high_bad !== 0) begin n_bad++; $display("FAIL stream_sclk_duty: got %0d high times outside 250..260 want 0", high_bad); end
        n_cmp++; if (rise_bad !== 0) begin n_bad++; $display("FAIL stream_sclk_after_valid: got %0d want 0", rise_bad); end
    endtask

    initial begin
        test_reset();
        test_long_slot();
        test_short_slot();
        test_dac();
        test_same_cycle();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
